// File: rtl/pipeline_stall_controller.sv
// Per-stage freeze/flush sequencing for the 5-stage pipeline.
// Tracks the SRAM wait time against a watchdog and keeps a saturating count of stall cycles.
module pipeline_stall_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_mem,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;

  // Controls are zero-latency so the pipeline registers see them in the same cycle.
  always_comb begin
    mem_stall    = 1'b0;
    freeze_if    = 1'b0;
    freeze_id    = 1'b0;
    freeze_mem   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    mem_timeout  = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_RUN:      mem_stall = mem_req & ~sram_ready;
        ST_MEM_WAIT: mem_stall = ~sram_ready;
        ST_ERROR:    mem_stall = 1'b1;
        default:     mem_stall = 1'b1;
      endcase
      freeze_mem   = mem_stall;
      freeze_id    = mem_stall;
      freeze_if    = mem_stall | (hazard_detected & ~branch_taken);
      flush_if_id  = branch_taken & ~mem_stall;
      flush_id_exe = ~mem_stall & (branch_taken | hazard_detected);
      mem_timeout  = (state == ST_ERROR);
    end
  end

  // State, SRAM wait watchdog and saturating stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (mem_req && !sram_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (sram_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
      if (freeze_if && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller, built with TIMEOUT=4 and CNT_W=3.
module tb_pipeline_stall_controller;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             freeze_if;
  logic             freeze_id;
  logic             freeze_mem;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  pipeline_stall_controller #(
    .TIMEOUT(TIMEOUT),
    .WAIT_W (WAIT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard_detected(hazard_detected),
    .branch_taken   (branch_taken),
    .mem_req        (mem_req),
    .sram_ready     (sram_ready),
    .freeze_if      (freeze_if),
    .freeze_id      (freeze_id),
    .freeze_mem     (freeze_mem),
    .flush_if_id    (flush_if_id),
    .flush_id_exe   (flush_id_exe),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  // Output vector order: freeze_if freeze_id freeze_mem flush_if_id flush_id_exe mem_timeout
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_HAZ   = 6'b100010;
  localparam logic [5:0] O_MEM   = 6'b111000;
  localparam logic [5:0] O_BR    = 6'b000110;
  localparam logic [5:0] O_ERR   = 6'b111001;

  function automatic logic [5:0] outs();
    return {freeze_if, freeze_id, freeze_mem, flush_if_id, flush_id_exe, mem_timeout};
  endfunction

  // Apply inputs away from the rising edge; checks follow 1ns later.
  task automatic drive(input logic r, input logic h, input logic b, input logic m, input logic s);
    @(negedge clk);
    rst = r; hazard_detected = h; branch_taken = b; mem_req = m; sram_ready = s;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = outs();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
    vectors++;
    assert (stall_cycles === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, stall_cycles, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;

    // Reset with every input high: outputs held low.
    drive(1, 1, 1, 1, 0); chk_outs("reset_c1", O_IDLE);
    drive(1, 1, 1, 1, 1); chk_outs("reset_c2", O_IDLE);
    drive(0, 0, 0, 0, 0); chk_outs("reset_rel", O_IDLE); chk_cnt("reset_cnt", 3'd0);

    // Load-use hazard for two cycles.
    drive(0, 1, 0, 0, 0); chk_outs("haz_c1", O_HAZ);
    drive(0, 1, 0, 0, 0); chk_outs("haz_c2", O_HAZ);
    drive(0, 0, 0, 0, 0); chk_outs("haz_end", O_IDLE); chk_cnt("haz_cnt", 3'd2);

    // Single-cycle SRAM access: no stall.
    drive(0, 0, 0, 1, 1); chk_outs("mem_fast", O_IDLE);

    // Three wait cycles, then ready drops the freeze in the same cycle.
    drive(0, 0, 0, 1, 0); chk_outs("wait_c1", O_MEM);
    drive(0, 0, 0, 1, 0); chk_outs("wait_c2", O_MEM);
    drive(0, 0, 0, 1, 0); chk_outs("wait_c3", O_MEM);
    drive(0, 0, 0, 1, 1); chk_outs("wait_ready", O_IDLE);
    drive(0, 0, 0, 1, 1); chk_outs("wait_back_run", O_IDLE); chk_cnt("wait_cnt", 3'd5);
    drive(0, 0, 0, 0, 0); chk_outs("wait_idle", O_IDLE);

    // Branch held across a two-cycle SRAM wait: flush only on the ready cycle.
    drive(0, 0, 1, 1, 0); chk_outs("brw_c1", O_MEM);
    drive(0, 0, 1, 1, 0); chk_outs("brw_c2", O_MEM);
    drive(0, 0, 1, 1, 1); chk_outs("brw_ready", O_BR);
    drive(0, 0, 0, 0, 0); chk_outs("brw_idle", O_IDLE); chk_cnt("brw_cnt", 3'd7);

    // Hazard coincident with branch: branch wins, no freeze.
    drive(0, 1, 1, 0, 0); chk_outs("haz_br", O_BR);
    drive(0, 1, 0, 0, 0); chk_outs("haz_sat", O_HAZ);
    drive(0, 0, 0, 0, 0); chk_cnt("cnt_held_7", 3'd7);

    // Watchdog: five wait cycles then ERROR, sticky until reset.
    drive(1, 0, 0, 0, 0); chk_outs("to_rst", O_IDLE);
    drive(0, 0, 0, 1, 0); chk_cnt("to_cnt0", 3'd0);
    for (int i = 1; i <= 5; i++) begin
      chk_outs($sformatf("to_wait%0d", i), O_MEM);
      drive(0, 0, 0, 1, 0);
    end
    chk_outs("to_error", O_ERR);
    drive(0, 0, 0, 1, 1); chk_outs("to_sticky_ready", O_ERR);
    drive(0, 1, 1, 0, 1); chk_outs("to_sticky_br", O_ERR); chk_cnt("to_cnt_sat", 3'd7);
    drive(1, 1, 1, 1, 1); chk_outs("to_in_rst", O_IDLE);
    drive(0, 0, 0, 0, 0); chk_outs("to_cleared", O_IDLE); chk_cnt("to_cnt_clr", 3'd0);

    // Saturation: ten hazard cycles on a 3-bit counter.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0);
      chk_cnt($sformatf("sat_c%0d", i), (i > 7) ? 3'd7 : CNT_W'(i));
    end
    drive(0, 0, 0, 0, 0); chk_cnt("sat_final", 3'd7);
    drive(0, 0, 0, 0, 0); chk_cnt("sat_stays", 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
